// File: rtl/csr_uart_tx.sv
// csr_uart_tx: CSR-mapped 8N1 UART transmitter.
// A write to CSR_ADDR queues wdata[7:0]; a read returns {busy, overflow, full}.
// Build option: define UART_TX_FIFO_EN for a 2**DEPTH_LOG2-entry FIFO;
// without it a single holding register buffers one byte.
module csr_uart_tx #(
  parameter logic [11:0] CSR_ADDR   = 12'hbc0,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        valid_q;
  logic [31:0] rdata_q;

  logic       rd_hit, wr_hit, push, drop, pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       baud_end;

  // Upper write-data bits carry no meaning for this register.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign rd_hit = read && (addr == CSR_ADDR);
  assign wr_hit = (modify == 3'd1) && (addr == CSR_ADDR);
  // Fullness is the pre-edge value, so a same-cycle pop never makes room.
  assign push   = wr_hit && !fifo_full;
  assign drop   = wr_hit && fifo_full;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, rptr_q;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                      (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign fifo_head  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // FIFO storage, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata[7:0];
  end
`else
  localparam int unsigned UNUSED_DEPTH_LOG2 = DEPTH_LOG2;

  logic [7:0] hold_q;
  logic       hold_v_q;

  assign fifo_full  = hold_v_q;
  assign fifo_empty = !hold_v_q;
  assign fifo_head  = hold_q;

  // Single-entry holding register; push and pop are mutually exclusive here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (push) begin
      hold_q   <= wdata[7:0];
      hold_v_q <= 1'b1;
    end else if (pop) begin
      hold_v_q <= 1'b0;
    end
  end
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  // Transmit FSM next-state: frame sequencing, baud/bit counting, FIFO pop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the registered state one cycle later, which gives the
  // two-edge write-to-start latency while keeping every bit BAUD_DIV wide.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped write wins over the clear-on-read.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)        ovf_d = 1'b1;
    else if (rd_hit) ovf_d = 1'b0;
  end

  // All state registers, including the CSR read response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      valid_q <= rd_hit;
      rdata_q <= rd_hit ? {29'd0, (state_q != IDLE), ovf_q, fifo_full} : '0;
    end
  end

  assign tx    = tx_q;
  assign valid = valid_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_csr_uart_tx.sv
// tb_csr_uart_tx: scoreboard bench for csr_uart_tx (BAUD_DIV=4).
// Stimulus pushes expected frames / read responses; a negedge monitor decodes
// the serial line and CSR responses and compares against the queues.
module tb_csr_uart_tx;

  localparam int unsigned B   = 4;
  localparam logic [11:0] CSR = 12'hbc0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid;
  logic        tx;

  csr_uart_tx #(.CSR_ADDR(CSR), .BAUD_DIV(B), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         b2b;
  } frame_t;

  frame_t      txq[$];
  logic [31:0] rq[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Monitor: serial frame decoder and CSR read response checker.
  int     ncyc = 0;
  int     last_end = -100;
  bit     in_frame = 0;
  int     pos;
  int     bad;
  logic [7:0] rxb;
  frame_t cur;

  always @(negedge clk) begin
    ncyc++;
    if (rstn !== 1'b1) begin
      in_frame = 0;
      txq.delete();
      rq.delete();
    end else begin
      if (valid === 1'b1) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: got rdata %h want no response", rdata);
        end else begin
          check("read_rdata", rdata, rq.pop_front());
        end
      end else begin
        check("rdata_zero_when_invalid", rdata, 32'h0);
      end

      if (in_frame) begin
        int idx;
        logic eb;
        idx = pos / B;
        if (idx == 0)      eb = 1'b0;
        else if (idx <= 8) eb = cur.d[idx-1];
        else               eb = 1'b1;
        if (tx !== eb) bad++;
        if (idx >= 1 && idx <= 8 && (pos % B) == B/2) rxb[idx-1] = tx;
        pos++;
        if (pos == 10*B) begin
          in_frame = 0;
          last_end = ncyc;
          n_chk++;
          if (bad != 0 || rxb !== cur.d) begin
            n_fail++;
            $display("FAIL frame: got byte %h with %0d bad samples, want %h", rxb, bad, cur.d);
          end
        end
      end else if (tx === 1'b0) begin
        if (txq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d, want idle line", ncyc);
        end else begin
          cur = txq.pop_front();
          if (cur.b2b) check("gapless_start", ncyc, last_end + 1);
          in_frame = 1;
          pos = 1;
          bad = 0;
          rxb = '0;
        end
      end
    end
  end

  task automatic idle_in();
    read = 0; modify = 3'd0; wdata = '0; addr = CSR;
  endtask

  task automatic wr(input logic [7:0] b, input bit exp, input bit b2b);
    modify = 3'd1; addr = CSR; wdata = {24'hA5C3F0, b};
    if (exp) txq.push_back('{d: b, b2b: b2b});
    @(negedge clk);
    modify = 3'd0; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] v);
    read = 1; addr = CSR;
    rq.push_back(v);
    @(negedge clk);
    read = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nh;
    rstn = 0;
    idle_in();
    wait_cyc(3);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_rdata", rdata, 32'h0);
    rstn = 1;
    wait_cyc(1);

    // Read at a foreign address gets no acknowledge.
    read = 1; addr = 12'h3ff;
    @(negedge clk);
    read = 0; addr = CSR;
    check("nomatch_valid", {31'd0, valid}, 32'd0);
    check("nomatch_rdata", rdata, 32'h0);
    // Read while idle and empty: one-cycle ack with zero status.
    rd(32'h0);
    @(negedge clk);
    check("ack_one_cycle", {31'd0, valid}, 32'd0);

    // Single byte and start latency.
    wr(8'h55, 1, 0);
    @(negedge clk);
    check("latency_edge1_high", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("latency_edge2_low", {31'd0, tx}, 32'd0);
    wait_cyc(45);

`ifdef UART_TX_FIFO_EN
    // Back-to-back frames.
    wr(8'h41, 1, 0);
    wr(8'h42, 1, 1);
    wr(8'h43, 1, 1);
    wait_cyc(130);
    check("b2b_idle_after", {31'd0, tx}, 32'd1);
    check("b2b_all_sent", txq.size(), 32'd0);

    // Overflow: one in the shifter plus eight queued, tenth dropped.
    for (int i = 1; i <= 10; i++) wr(8'(i), i <= 9, i > 1);
    rd(32'h7);
    wait_cyc(60);
    rd(32'h4);
    wait_cyc(360);
    rd(32'h0);
    wait_cyc(3);
`else
    // Holding register: second write hits a full register and is dropped.
    wr(8'h11, 1, 0);
    wr(8'h22, 0, 0);
    wr(8'h33, 1, 1);
    rd(32'h7);
    wait_cyc(50);
    rd(32'h4);
    wait_cyc(100);
    rd(32'h0);
    wait_cyc(3);
`endif
    check("frames_drained", txq.size(), 32'd0);

    // Reset during data bit 3 of 8'hA5 with bytes queued behind it.
    wr(8'hA5, 1, 0);
    wait_cyc(1);
    wr(8'h5A, 1, 1);
`ifdef UART_TX_FIFO_EN
    wr(8'h3C, 1, 1);
`else
    wait_cyc(1);
`endif
    wait_cyc(16);
    check("pre_reset_bit3", {31'd0, tx}, 32'd0);
    rstn = 0;
    @(negedge clk);
    check("reset_abort_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rstn = 1;
    nh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) nh++;
    end
    check("post_reset_quiet", nh, 32'd0);
    rd(32'h0);
    wait_cyc(2);

    check("scoreboard_tx_empty", txq.size(), 32'd0);
    check("scoreboard_rd_empty", rq.size(), 32'd0);
    check("monitor_idle", {31'd0, in_frame}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
